// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer:
// state encoding, opcode/funct values and datapath select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEM_ADDR = 4'd3,
    S_MEM_RD   = 4'd4,
    S_MEM_WB   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_R_EXEC   = 4'd7,
    S_R_WB     = 4'd8,
    S_I_EXEC   = 4'd9,
    S_I_WB     = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_HALT     = 4'd13,
    S_TRAP     = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_RT     = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } pcsrc_t;

  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// R-type funct decoder: maps funct to the ALU control code and flags
// whether the funct is one the controller supports.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_ctrl,
  output logic       legal
);

  // Funct lookup; unsupported values report legal=0 with a harmless add code.
  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: legal    = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath.
// Optional feature: define MIPS_BRANCH_EN to build the beq/j states;
// without it those opcodes trap and pc_write_cond/pc_source stay 0.
//
// state     | meaning
// RESET     | idle after reset, all outputs low
// FETCH     | read instruction, PC+4 (waits on mem_ready)
// DECODE    | register read, branch target into ALUOut
// MEM_ADDR  | lw/sw effective address
// MEM_RD    | data read (waits on mem_ready)
// MEM_WB    | load data into rt
// MEM_WR    | data write (waits on mem_ready)
// R_EXEC    | R-type ALU operation
// R_WB      | R-type result into rd
// I_EXEC    | addi ALU operation
// I_WB      | addi result into rt
// BRANCH    | beq compare and conditional PC load
// JUMP      | jump target into PC
// HALT      | NOP seen, parked until reset
// TRAP      | illegal encoding, parked until reset
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_ctrl,
  output logic [1:0]       pc_source,
  output logic             halted,
  output logic             trap,
  output logic [CNT_W-1:0] instr_count
);

  state_t     state, state_nxt;
  logic [5:0] opcode;
  logic [2:0] funct_ctrl;
  logic       funct_legal;
  logic       retire;

  // The zero flag qualifies the PC load inside the datapath, not here.
  logic unused_ok;
  assign unused_ok = ^{instr[25:6], zero};

  assign opcode = opcode_of(instr);

  alu_decoder u_alu_decoder (
    .funct    (instr[5:0]),
    .alu_ctrl (funct_ctrl),
    .legal    (funct_legal)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RESET;
    else       state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        if (instr == 32'h0)                          state_nxt = S_HALT;
        else if (opcode == OP_LW || opcode == OP_SW) state_nxt = S_MEM_ADDR;
        else if (opcode == OP_RTYPE && funct_legal)  state_nxt = S_R_EXEC;
        else if (opcode == OP_ADDI)                  state_nxt = S_I_EXEC;
`ifdef MIPS_BRANCH_EN
        else if (opcode == OP_BEQ)                   state_nxt = S_BRANCH;
        else if (opcode == OP_J)                     state_nxt = S_JUMP;
`else
        else if (opcode == OP_BEQ || opcode == OP_J) state_nxt = S_TRAP;
`endif
        else                                         state_nxt = S_TRAP;
      end
      S_MEM_ADDR: state_nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_nxt = S_MEM_WB;
      S_MEM_WB:   state_nxt = S_FETCH;
      S_MEM_WR:   if (mem_ready) state_nxt = S_FETCH;
      S_R_EXEC:   state_nxt = S_R_WB;
      S_R_WB:     state_nxt = S_FETCH;
      S_I_EXEC:   state_nxt = S_I_WB;
      S_I_WB:     state_nxt = S_FETCH;
`ifdef MIPS_BRANCH_EN
      S_BRANCH:   state_nxt = S_FETCH;
      S_JUMP:     state_nxt = S_FETCH;
`endif
      S_HALT:     state_nxt = S_HALT;
      S_TRAP:     state_nxt = S_TRAP;
      default:    state_nxt = S_TRAP;
    endcase
  end

  // Moore outputs; FETCH gates its IR/PC loads with mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_RT;
    alu_ctrl      = 3'b000;
    pc_source     = PCSRC_ALU;
    halted        = 1'b0;
    trap          = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        alu_src_b = SRCB_FOUR;
        alu_ctrl  = ALU_ADD;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        alu_ctrl  = ALU_ADD;
      end
      S_MEM_ADDR, S_I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_ctrl  = ALU_ADD;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_ctrl;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        alu_ctrl  = funct_ctrl;
      end
      S_I_WB:   reg_write = 1'b1;
`ifdef MIPS_BRANCH_EN
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
      end
`endif
      S_HALT:   halted = 1'b1;
      S_TRAP:   trap   = 1'b1;
      default: ;
    endcase
  end

  // An instruction retires on the edge that leaves its last state.
  always_comb begin
    case (state)
      S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retire = 1'b1;
      S_MEM_WR: retire = mem_ready;
      default:  retire = 1'b0;
    endcase
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_count <= '0;
    else if (retire) instr_count <= instr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Outputs are packed into one
// vector {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
// mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_ctrl,
// pc_source, halted, trap} and compared against hand-written constants.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, halted, trap;
  logic [1:0]  alu_src_b, pc_source;
  logic [2:0]  alu_ctrl;
  logic [31:0] instr_count;
  logic [18:0] obs;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr         (instr),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .mem_to_reg    (mem_to_reg),
    .reg_dst       (reg_dst),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_ctrl      (alu_ctrl),
    .pc_source     (pc_source),
    .halted        (halted),
    .trap          (trap),
    .instr_count   (instr_count)
  );

  always #5 clk = ~clk;

  assign obs = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
                alu_ctrl, pc_source, halted, trap};

  //                               pcw   pcwc  iord  mrd   mwr   irw   m2r   rdst  rwr   srca  srcb  aluc    pcsrc hlt,trp
  localparam logic [18:0] E_RESET   = 19'h0;
  localparam logic [18:0] E_FETCH   = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'b010, 2'd0, 2'b00};
  localparam logic [18:0] E_FWAIT   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 3'b010, 2'd0, 2'b00};
  localparam logic [18:0] E_DECODE  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 3'b010, 2'd0, 2'b00};
  localparam logic [18:0] E_MADDR   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'b010, 2'd0, 2'b00};
  localparam logic [18:0] E_MRD     = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'd0, 2'b00};
  localparam logic [18:0] E_MWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 2'd0, 2'b00};
  localparam logic [18:0] E_MWR     = {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'd0, 2'b00};
  localparam logic [18:0] E_IEXEC   = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'b010, 2'd0, 2'b00};
  localparam logic [18:0] E_IWB     = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 2'd0, 2'b00};
  localparam logic [18:0] E_REX_ADD = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b010, 2'd0, 2'b00};
  localparam logic [18:0] E_REX_SUB = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b110, 2'd0, 2'b00};
  localparam logic [18:0] E_RWB_ADD = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'b010, 2'd0, 2'b00};
  localparam logic [18:0] E_RWB_SUB = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 3'b110, 2'd0, 2'b00};
  localparam logic [18:0] E_BRANCH  = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'b110, 2'd1, 2'b00};
  localparam logic [18:0] E_JUMP    = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 2'd2, 2'b00};
  localparam logic [18:0] E_HALT    = {17'h0, 2'b10};
  localparam logic [18:0] E_TRAP    = {17'h0, 2'b01};

  localparam logic [31:0] I_ADDI10 = 32'h200A000A;  // addi $10,$0,10
  localparam logic [31:0] I_ADD    = 32'h014B6020;  // add  $12,$10,$11
  localparam logic [31:0] I_ADDI11 = 32'h200B0003;  // addi $11,$0,3
  localparam logic [31:0] I_SUB    = 32'h014B6022;  // sub  $12,$10,$11
  localparam logic [31:0] I_SW     = 32'hAD4D0004;  // sw   $13,4($10)
  localparam logic [31:0] I_LW     = 32'h8D4D0000;  // lw   $13,0($10)
  localparam logic [31:0] I_BADOP  = 32'hFC000000;  // opcode 0x3F
  localparam logic [31:0] I_BADFN  = 32'h014B6018;  // funct 0x18
  localparam logic [31:0] I_BEQ    = 32'h114B0003;  // beq  $10,$11,3
  localparam logic [31:0] I_J      = 32'h08000010;  // j    0x40

  task automatic chk(input string tag, input logic [18:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: outputs got %05h expected %05h", tag, obs, expv);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [31:0] expv);
    checks++;
    assert (instr_count === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s: instr_count got %0d expected %0d", tag, instr_count, expv);
    end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    #1;
    chk("reset_pulse", E_RESET);
    reset = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset_outputs", E_RESET);
    chk_cnt("reset_count", 32'd0);

    // addi: 4 cycles FETCH..I_WB
    reset = 1'b0;
    instr = I_ADDI10;
    step(); chk("addi_fetch", E_FETCH);
    step(); chk("addi_decode", E_DECODE);
    step(); chk("addi_exec", E_IEXEC);
    step(); chk("addi_wb", E_IWB);
    chk_cnt("addi_cnt_before", 32'd0);

    // add, with one FETCH wait state
    instr = I_ADD;
    step(); chk("add_fetch", E_FETCH);
    chk_cnt("addi_retired", 32'd1);
    mem_ready = 1'b0;
    #1; chk("fetch_gated", E_FWAIT);
    step(); chk("fetch_held", E_FWAIT);
    mem_ready = 1'b1;
    #1; chk("fetch_ready", E_FETCH);
    step(); chk("add_decode", E_DECODE);
    step(); chk("add_exec", E_REX_ADD);
    step(); chk("add_wb", E_RWB_ADD);

    instr = I_ADDI11;
    step(); chk("addi2_fetch", E_FETCH);
    chk_cnt("add_retired", 32'd2);
    step(); chk("addi2_decode", E_DECODE);
    step(); chk("addi2_exec", E_IEXEC);
    step(); chk("addi2_wb", E_IWB);

    // sub: alu_ctrl 110 in both R states
    instr = I_SUB;
    step(); chk("sub_fetch", E_FETCH);
    chk_cnt("addi2_retired", 32'd3);
    step(); chk("sub_decode", E_DECODE);
    step(); chk("sub_exec", E_REX_SUB);
    step(); chk("sub_wb", E_RWB_SUB);

    instr = I_SW;
    step(); chk("sw_fetch", E_FETCH);
    chk_cnt("sub_retired", 32'd4);
    step(); chk("sw_decode", E_DECODE);
    step(); chk("sw_addr", E_MADDR);
    step(); chk("sw_write", E_MWR);

    // lw with two stall cycles in MEM_RD: 7 cycles total
    instr = I_LW;
    step(); chk("lw_fetch", E_FETCH);
    chk_cnt("sw_retired", 32'd5);
    step(); chk("lw_decode", E_DECODE);
    step(); chk("lw_addr", E_MADDR);
    mem_ready = 1'b0;
    step(); chk("lw_read1", E_MRD);
    step(); chk("lw_read2", E_MRD);
    step(); chk("lw_read3", E_MRD);
    mem_ready = 1'b1;
    #1; chk("lw_read3_ready", E_MRD);
    step(); chk("lw_wb", E_MWB);
    chk_cnt("lw_cnt_before", 32'd5);

    // NOP halts; halted is sticky and ignores mem_ready
    instr = 32'h0;
    step(); chk("nop_fetch", E_FETCH);
    chk_cnt("lw_retired", 32'd6);
    step(); chk("nop_decode", E_DECODE);
    step(); chk("halt", E_HALT);
    mem_ready = 1'b0;
    step(); chk("halt_hold1", E_HALT);
    mem_ready = 1'b1;
    step(); chk("halt_hold2", E_HALT);
    chk_cnt("halt_count", 32'd6);

    // Async reset clears halt and counter; FETCH one cycle later
    reset = 1'b1;
    #1; chk("reset_async", E_RESET);
    chk_cnt("reset_clears_count", 32'd0);
    step(); chk("reset_held", E_RESET);
    reset = 1'b0;
    instr = I_BADOP;
    step(); chk("refetch_after_reset", E_FETCH);
    step(); chk("badop_decode", E_DECODE);
    step(); chk("badop_trap", E_TRAP);
    step(); chk("badop_trap_sticky", E_TRAP);
    chk_cnt("trap_no_count", 32'd0);

    pulse_reset();
    instr = I_BADFN;
    step(); chk("badfn_fetch", E_FETCH);
    step(); chk("badfn_decode", E_DECODE);
    step(); chk("badfn_trap", E_TRAP);

    // Reset drops an outstanding read in FETCH and a write in MEM_WR
    pulse_reset();
    instr = I_SW;
    mem_ready = 1'b0;
    step(); chk("fetch_pending", E_FWAIT);
    reset = 1'b1;
    #1; chk("reset_drops_read", E_RESET);
    reset = 1'b0;
    mem_ready = 1'b1;
    step(); chk("sw2_fetch", E_FETCH);
    step(); chk("sw2_decode", E_DECODE);
    step(); chk("sw2_addr", E_MADDR);
    mem_ready = 1'b0;
    step(); chk("sw2_write_wait1", E_MWR);
    step(); chk("sw2_write_wait2", E_MWR);
    reset = 1'b1;
    #1; chk("reset_drops_write", E_RESET);
    chk_cnt("dropped_write_not_counted", 32'd0);
    reset = 1'b0;
    mem_ready = 1'b1;

    // beq / j
    instr = I_BEQ;
    zero  = 1'b1;
    step(); chk("beq_fetch", E_FETCH);
    step(); chk("beq_decode", E_DECODE);
`ifdef MIPS_BRANCH_EN
    step(); chk("beq_branch", E_BRANCH);
    instr = I_J;
    step(); chk("j_fetch", E_FETCH);
    chk_cnt("beq_retired", 32'd1);
    step(); chk("j_decode", E_DECODE);
    step(); chk("j_jump", E_JUMP);
    step(); chk("after_j_fetch", E_FETCH);
    chk_cnt("j_retired", 32'd2);
`else
    step(); chk("beq_trap", E_TRAP);
    pulse_reset();
    instr = I_J;
    step(); chk("j_fetch", E_FETCH);
    step(); chk("j_decode", E_DECODE);
    step(); chk("j_trap", E_TRAP);
    chk_cnt("branch_trap_count", 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
